// File: rtl/memory_access_pkg.sv
// Shared constants and types for the pipeline MEM stage: opcodes, funct3
// widths, the bubble instruction and the request FSM state encoding.
package memory_access_pkg;

  localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPCODE_STORE = 7'b0100011;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  // Unsigned variants only exist for loads; any other code is a word access.
  function automatic mem_size_t access_size(input logic is_load, input logic [2:0] f3);
    mem_size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (is_load && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (is_load && f3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and
// the data memory (slave).
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_access_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and sign- or
// zero-extends it according to funct3. Purely combinational.
module memory_access_load_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'd0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Pipeline MEM stage: issues loads/stores over a req/ack port, stalls while an
// access is outstanding and registers writeback values. MEM_TIMEOUT_EN adds a
// WAIT-state timeout that aborts the access and pulses bus_error_wb.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] alu_mem,
  input  logic [XLEN-1:0] rs2_mem,
  input  logic [31:0]     instr_mem,
  memory_access_if.master dmem,
  output logic            stall,
  output logic [XLEN-1:0] pc_wb,
  output logic [31:0]     instr_wb,
  output logic [XLEN-1:0] rd_data_wb,
  output logic            misaligned_wb,
  output logic [XLEN-1:0] forward_mem
`ifdef MEM_TIMEOUT_EN
  ,
  output logic            bus_error_wb
`endif
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic        aligned_op;
  mem_size_t   size;
  logic [31:0] load_data;

  assign opcode   = instr_mem[6:0];
  assign funct3   = instr_mem[14:12];
  assign addr_lo  = alu_mem[1:0];
  assign is_load  = (opcode == OPCODE_LOAD);
  assign is_store = (opcode == OPCODE_STORE);
  assign is_mem   = is_load | is_store;
  assign size     = access_size(is_load, funct3);

  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      SZ_H:    misaligned = addr_lo[0];
      SZ_W:    misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    misaligned = misaligned & is_mem;
  end

  assign aligned_op = is_mem & ~misaligned;

  // Store lane steering; loads always read the full word.
  always_comb begin
    dmem.addr  = {alu_mem[31:2], 2'b00};
    dmem.we    = is_store;
    dmem.be    = 4'b1111;
    dmem.wdata = rs2_mem;
    if (is_store) begin
      unique case (size)
        SZ_B: begin
          dmem.be    = 4'b0001 << addr_lo;
          dmem.wdata = {4{rs2_mem[7:0]}};
        end
        SZ_H: begin
          dmem.be    = 4'b0011 << addr_lo;
          dmem.wdata = {2{rs2_mem[15:0]}};
        end
        default: begin
          dmem.be    = 4'b1111;
          dmem.wdata = rs2_mem;
        end
      endcase
    end
  end

  memory_access_load_align u_load_align (
    .funct3  (funct3),
    .addr_lo (addr_lo),
    .rdata   (dmem.rdata),
    .data    (load_data)
  );

  mem_state_t state_q, state_d;
  logic       req_c;
  logic       timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    req_c       = 1'b0;
    timeout_hit = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (aligned_op) begin
          req_c = 1'b1;
          if (!dmem.ack) begin
            state_d = WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
`ifdef MEM_TIMEOUT_EN
        // The request is dropped in the abort cycle, so a late ack is ignored.
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          req_c = 1'b1;
          if (dmem.ack) state_d = IDLE;
          else          cnt_d   = cnt_q + 1'b1;
        end
`else
        req_c = 1'b1;
        if (dmem.ack) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (rst) req_c = 1'b0;
  end

  assign dmem.req = req_c;
  assign stall    = req_c & ~dmem.ack;

  logic [XLEN-1:0] pc_wb_q, pc_wb_d;
  logic [31:0]     instr_wb_q, instr_wb_d;
  logic [XLEN-1:0] rd_data_wb_q, rd_data_wb_d;
  logic            misaligned_wb_q, misaligned_wb_d;
  logic            bus_error_wb_d;

  always_comb begin
    pc_wb_d         = pc_wb_q;
    instr_wb_d      = NOP_INSTR;
    rd_data_wb_d    = rd_data_wb_q;
    misaligned_wb_d = 1'b0;
    bus_error_wb_d  = 1'b0;
    if (misaligned) begin
      pc_wb_d         = pc_mem;
      misaligned_wb_d = 1'b1;
    end else if (stall) begin
      pc_wb_d = pc_wb_q;
    end else if (timeout_hit) begin
      bus_error_wb_d = 1'b1;
    end else begin
      pc_wb_d      = pc_mem;
      instr_wb_d   = instr_mem;
      rd_data_wb_d = is_load ? load_data : alu_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_wb_q         <= '0;
      instr_wb_q      <= NOP_INSTR;
      rd_data_wb_q    <= '0;
      misaligned_wb_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_wb_q         <= pc_wb_d;
      instr_wb_q      <= instr_wb_d;
      rd_data_wb_q    <= rd_data_wb_d;
      misaligned_wb_q <= misaligned_wb_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic bus_error_wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      bus_error_wb_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bus_error_wb_q <= bus_error_wb_d;
    end
  end

  assign bus_error_wb = bus_error_wb_q;
`else
  logic unused_timeout;
  assign unused_timeout = bus_error_wb_d;
`endif

  assign pc_wb         = pc_wb_q;
  assign instr_wb      = instr_wb_q;
  assign rd_data_wb    = rd_data_wb_q;
  assign misaligned_wb = misaligned_wb_q;
  assign forward_mem   = rd_data_wb_q;

endmodule
